// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg
//   Shared types and constants for the CPU clock-enable controller.
//   state_t            : controller FSM states (BURST only reachable when
//                        CPU_CLK_BURST_EN is defined)
//   CE_COUNT_W         : width of the front-panel cpu_ce counter
//   DEB_CYCLES_DEFAULT : debounce hold time at the board clock
package cpu_clk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        HALTED,
        BURST
    } state_t;

    localparam int CE_COUNT_W           = 16;
    localparam int DEB_CYCLES_DEFAULT   = 1_000_000;
    localparam int DEB_W_DEFAULT        = 20;
    localparam int SYNC_STAGES_DEFAULT  = 2;

    // Burst length field of the optional burst_n input.
    localparam int BURST_W              = 4;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Synchronises a raw, bouncy push-button, debounces it and emits a
//   one-cycle pulse on each debounced rising edge.
//   Parameters: DEB_CYCLES  cycles the synced level must hold to be accepted
//               DEB_W       counter width (2**DEB_W > DEB_CYCLES)
//               SYNC_STAGES synchroniser depth
//   Ports: CLK, CLRn (async, active-low)
//          btn    in  raw asynchronous button
//          press  out one-CLK pulse when the debounced level goes 0 -> 1
module btn_debounce #(
    parameter int DEB_CYCLES  = 4,
    parameter int DEB_W       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic CLRn,
    input  logic btn,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable;
    logic [DEB_W-1:0]       cnt;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            sync_q <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_q[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];

            press <= 1'b0;
            // Any return to the accepted level restarts the hold timer, so
            // only an uninterrupted run of DEB_CYCLES differing samples
            // changes the stable level.
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
                stable <= synced;
                cnt    <= '0;
                // Registered alongside stable, so it coincides with the
                // cycle stable first reads 1.
                press  <= synced;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
//   Converts the divider's slow-clock level into a one-CLK CPU clock enable.
//   Run mode fires once per slow-clock rising edge, step mode once per
//   debounced step-button press. A CPU HLT request parks the controller in
//   HALTED until the next press.
//   Optional feature (macro CPU_CLK_BURST_EN): adds burst_n; a press in step
//   mode then issues burst_n+1 enables, one per slow-clock rising edge.
//   Ports: CLK, CLRn (async, active-low)
//          tick      in  slow-clock level, synchronous to CLK
//          mode_run  in  1 = run, 0 = single step (asynchronous)
//          step_btn  in  raw step button, active-high (asynchronous)
//          halt_req  in  CPU HLT decode, synchronous to CLK
//          burst_n   in  burst length - 1 (CPU_CLK_BURST_EN only)
//          cpu_ce    out CPU clock enable, one CLK wide, latency 1
//          halted    out 1 while HALTED
//          run_led   out 1 while RUN
//          ce_count  out number of cpu_ce pulses issued, wraps
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int DEB_W       = DEB_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  CLRn,
    input  logic                  tick,
    input  logic                  mode_run,
    input  logic                  step_btn,
    input  logic                  halt_req,
`ifdef CPU_CLK_BURST_EN
    input  logic [BURST_W-1:0]    burst_n,
`endif
    output logic                  cpu_ce,
    output logic                  halted,
    output logic                  run_led,
    output logic [CE_COUNT_W-1:0] ce_count
);

    state_t                 state;
    logic [SYNC_STAGES-1:0] mode_sync;
    logic                   mode_s;
    logic                   tick_d;
    logic                   tick_edge;
    logic                   press;
`ifdef CPU_CLK_BURST_EN
    logic [BURST_W-1:0]     burst_left;
`endif

    // tick already lives in the CLK domain; only the edge is needed.
    assign tick_edge = tick & ~tick_d;
    assign mode_s    = mode_sync[SYNC_STAGES-1];

    btn_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .DEB_W       (DEB_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deb (
        .CLK   (CLK),
        .CLRn  (CLRn),
        .btn   (step_btn),
        .press (press)
    );

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            mode_sync <= '0;
            tick_d    <= 1'b0;
        end else begin
            mode_sync[0] <= mode_run;
            for (int i = 1; i < SYNC_STAGES; i++)
                mode_sync[i] <= mode_sync[i-1];
            tick_d <= tick;
        end
    end

    // Controller FSM. Branch order encodes priority: halt first, then a mode
    // change (which swallows any trigger in the same cycle), then the trigger.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state      <= IDLE;
            cpu_ce     <= 1'b0;
            halted     <= 1'b0;
            run_led    <= 1'b0;
            ce_count   <= '0;
`ifdef CPU_CLK_BURST_EN
            burst_left <= '0;
`endif
        end else begin
            cpu_ce <= 1'b0;
            case (state)
                IDLE: begin
                    if (mode_s) begin
                        state   <= RUN;
                        run_led <= 1'b1;
                    end else begin
                        state   <= STEP;
                    end
                end

                RUN: begin
                    if (halt_req) begin
                        state   <= HALTED;
                        halted  <= 1'b1;
                        run_led <= 1'b0;
                    end else if (!mode_s) begin
                        state   <= STEP;
                        run_led <= 1'b0;
                    end else if (tick_edge) begin
                        cpu_ce   <= 1'b1;
                        ce_count <= ce_count + CE_COUNT_W'(1);
                    end
                end

                STEP: begin
                    if (halt_req) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (mode_s) begin
                        state   <= RUN;
                        run_led <= 1'b1;
                    end else if (press) begin
`ifdef CPU_CLK_BURST_EN
                        // Pulses come later, paced by tick edges.
                        state      <= BURST;
                        burst_left <= burst_n;
`else
                        cpu_ce   <= 1'b1;
                        ce_count <= ce_count + CE_COUNT_W'(1);
`endif
                    end
                end

                HALTED: begin
                    // Leave via IDLE so the mode switch is re-evaluated.
                    if (press) begin
                        state  <= IDLE;
                        halted <= 1'b0;
                    end
                end

`ifdef CPU_CLK_BURST_EN
                BURST: begin
                    if (halt_req) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (tick_edge) begin
                        cpu_ce   <= 1'b1;
                        ce_count <= ce_count + CE_COUNT_W'(1);
                        if (burst_left == '0)
                            state <= STEP;
                        else
                            burst_left <= burst_left - BURST_W'(1);
                    end
                end
`endif

                default: begin
                    state   <= IDLE;
                    halted  <= 1'b0;
                    run_led <= 1'b0;
                end
            endcase
        end
    end

endmodule
